// File: rtl/div_issue_ctrl.sv
// EX-stage divide sequencer: latches operands, waits for the divider, hands the result to EX/MEM.
// Optional result-reuse cache enabled by defining DIV_RESULT_REUSE_EN.
module div_issue_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic            ex_is_div_i,
  input  logic [3:0]      ex_op_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  output logic [3:0]      div_op_o,
  output logic            div_valid_o,
  input  logic [XLEN-1:0] div_result_i,
  input  logic            div_ready_i,
  output logic            stall_o,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o
);

  // state | meaning
  // IDLE  | waiting for a divide-class op
  // BUSY  | operands held on divider inputs, waiting for div_ready_i
  // DONE  | result held for EX/MEM until wb_ready_i
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            accept, hit, timeout, handshake;

  assign accept    = ex_valid_i & ex_is_div_i & (ex_op_i[3:2] == 2'b11) & ~flush_i & (state_q == IDLE);
  assign timeout   = (state_q == BUSY) & ~div_ready_i & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign handshake = (state_q == DONE) & wb_ready_i & ~flush_i;

`ifdef DIV_RESULT_REUSE_EN
  logic            c_v_q, pend_q;
  logic [3:0]      c_op_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_res_q;

  assign hit = c_v_q & (ex_op_i == c_op_q) & (ex_rs1_i == c_a_q) & (ex_rs2_i == c_b_q);

  // pend_q marks a DONE result that came from the divider (or a hit), not from a timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_v_q   <= 1'b0;
      pend_q  <= 1'b0;
      c_op_q  <= '0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_res_q <= '0;
    end else if (flush_i) begin
      c_v_q  <= 1'b0;
      pend_q <= 1'b0;
    end else if (timeout) begin
      c_v_q  <= 1'b0;
      pend_q <= 1'b0;
    end else if ((state_q == BUSY) && div_ready_i) begin
      pend_q <= 1'b1;
    end else if (accept && hit) begin
      pend_q <= 1'b1;
    end else if (handshake) begin
      pend_q <= 1'b0;
      if (pend_q) begin
        c_v_q   <= 1'b1;
        c_op_q  <= op_q;
        c_a_q   <= a_q;
        c_b_q   <= b_q;
        c_res_q <= data_q;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_d   = ex_rs1_i;
            b_d   = ex_rs2_i;
            op_d  = ex_op_i;
            rd_d  = ex_rd_i;
            cnt_d = '0;
`ifdef DIV_RESULT_REUSE_EN
            if (hit) begin
              data_d  = c_res_q;
              state_d = DONE;
            end else begin
              state_d = BUSY;
            end
`else
            state_d = BUSY;
`endif
          end
        end
        BUSY: begin
          cnt_d = cnt_q + 1'b1;
          if (div_ready_i) begin
            data_d  = div_result_i;
            state_d = DONE;
          end else if (timeout) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (wb_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign div_a_o     = a_q;
  assign div_b_o     = b_q;
  assign div_op_o    = op_q;
  assign div_valid_o = (state_q == BUSY) & ~flush_i;
  assign wb_valid_o  = (state_q == DONE) & ~flush_i;
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = data_q;
  assign err_o       = err_q;
  // low in the handshake cycle so the next instruction advances on the same edge
  assign stall_o     = accept | (state_q == BUSY) | ((state_q == DONE) & ~wb_ready_i);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: vector table + scoreboard + timing corner sequences.
module tb_div_issue_ctrl;
  localparam int XLEN = 32;
  localparam int TO   = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid_i, ex_is_div_i, flush_i, div_ready_i, wb_ready_i;
  logic [3:0]      ex_op_i, div_op_o;
  logic [XLEN-1:0] ex_rs1_i, ex_rs2_i, div_a_o, div_b_o, div_result_i, wb_data_o;
  logic [4:0]      ex_rd_i, wb_rd_o;
  logic            div_valid_o, stall_o, wb_valid_o, err_o;
  logic            ready_en;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [3:0] op; logic [XLEN-1:0] a; logic [XLEN-1:0] b; logic [4:0] rd; logic [XLEN-1:0] exp;
  } vec_t;
  vec_t vecs[9];

  div_issue_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ex_is_div_i(ex_is_div_i),
    .ex_op_i(ex_op_i), .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
    .flush_i(flush_i), .div_a_o(div_a_o), .div_b_o(div_b_o), .div_op_o(div_op_o),
    .div_valid_o(div_valid_o), .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Behavioural combinational divider with RISC-V M semantics.
  function automatic logic [XLEN-1:0] rv_div(input logic [3:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      4'b1100: rv_div = (b == 0) ? '1 : ovf ? a : XLEN'($signed(a) / $signed(b));
      4'b1101: rv_div = (b == 0) ? '1 : a / b;
      4'b1110: rv_div = (b == 0) ? a : ovf ? '0 : XLEN'($signed(a) % $signed(b));
      default: rv_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  assign div_result_i = rv_div(div_op_o, div_a_o, div_b_o);
  assign div_ready_i  = ready_en & div_valid_o;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on every writeback handshake.
  always @(negedge clk) begin
    if (rst_n && wb_valid_o && wb_ready_i) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: wb rd=%0d data=0x%08h with nothing expected", wb_rd_o, wb_data_o);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        if (wb_rd_o !== e.rd || wb_data_o !== e.data) begin
          failures++;
          $display("FAIL sb_wb: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                   wb_rd_o, wb_data_o, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [4:0] rd, input logic [XLEN-1:0] exp);
    ex_valid_i = 1'b1; ex_is_div_i = 1'b1; ex_op_i = op;
    ex_rs1_i = a; ex_rs2_i = b; ex_rd_i = rd;
    sbq.push_back('{rd: rd, data: exp});
    #1;
  endtask

  task automatic idle_in();
    ex_valid_i = 1'b0; ex_is_div_i = 1'b0;
  endtask

  task automatic wait_wb(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (wb_valid_o) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: got no wb_valid expected wb_valid within 200 cycles", name);
    end
  endtask

  initial begin
    rst_n = 1'b0; ex_valid_i = 0; ex_is_div_i = 0; ex_op_i = 0; ex_rs1_i = 0; ex_rs2_i = 0;
    ex_rd_i = 0; flush_i = 0; wb_ready_i = 0; ready_en = 1;
    vecs[0] = '{4'b1100, 32'hFFFF_FFEC, 32'd3,          5'd5, 32'hFFFF_FFFA};
    vecs[1] = '{4'b1101, 32'd100,       32'd7,          5'd1, 32'd14};
    vecs[2] = '{4'b1110, 32'hFFFF_FFEC, 32'd3,          5'd2, 32'hFFFF_FFFE};
    vecs[3] = '{4'b1111, 32'd100,       32'd7,          5'd3, 32'd2};
    vecs[4] = '{4'b1101, 32'd5,         32'd0,          5'd4, 32'hFFFF_FFFF};
    vecs[5] = '{4'b1110, 32'h8000_0000, 32'hFFFF_FFFF,  5'd6, 32'd0};
    vecs[6] = '{4'b1100, 32'h8000_0000, 32'hFFFF_FFFF,  5'd7, 32'h8000_0000};
    vecs[7] = '{4'b1101, 32'd50,        32'd5,          5'd0, 32'd10};
    vecs[8] = '{4'b1111, 32'd7,         32'd0,          5'd9, 32'd7};

    #12;
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_div_valid", div_valid_o, 0);
    chk("rst_outs", {div_a_o, div_b_o, div_op_o, wb_data_o, wb_rd_o} == 0, 1);
    rst_n = 1'b1;
    tick();

    // Test 1: DIV -20/3, combinational divider, exact timing.
    wb_ready_i = 1'b1;
    drive(4'b1100, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'hFFFF_FFFA);
    chk("t1_stall_N", stall_o, 1);
    chk("t1_divvalid_N", div_valid_o, 0);
    tick(); idle_in(); #1;
    chk("t1_divvalid_N1", div_valid_o, 1);
    chk("t1_stall_N1", stall_o, 1);
    chk("t1_wbvalid_N1", wb_valid_o, 0);
    tick(); #1;
    chk("t1_wbvalid_N2", wb_valid_o, 1);
    chk("t1_data_N2", wb_data_o, 32'hFFFF_FFFA);
    chk("t1_rd_N2", wb_rd_o, 5);
    chk("t1_stall_N2", stall_o, 0);
    tick(); #1;
    chk("t1_wbvalid_N3", wb_valid_o, 0);

    // Ignored op code under ex_is_div.
    ex_valid_i = 1; ex_is_div_i = 1; ex_op_i = 4'b0100; #1;
    chk("ign_stall", stall_o, 0);
    tick(); #1;
    chk("ign_divvalid", div_valid_o, 0);
    idle_in();

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
      tick(); idle_in();
      wait_wb("vec");
      tick();
    end
    chk("vec_sb_empty", sbq.size(), 0);

    // Test 2: wb_ready_i low for 3 cycles.
    wb_ready_i = 1'b0;
    drive(4'b1100, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'hFFFF_FFFA);
    tick(); idle_in();
    wait_wb("t2");
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_hold_valid", wb_valid_o, 1);
      chk("t2_hold_data", wb_data_o, 32'hFFFF_FFFA);
      chk("t2_hold_stall", stall_o, 1);
      tick();
    end
    wb_ready_i = 1'b1; #1;
    chk("t2_hs_stall", stall_o, 0);
    tick(); #1;
    chk("t2_idle_valid", wb_valid_o, 0);
    chk("t2_sb_empty", sbq.size(), 0);

    // Test 3: flush while BUSY.
    ready_en = 1'b0;
    ex_valid_i = 1; ex_is_div_i = 1; ex_op_i = 4'b1111; ex_rs1_i = 100; ex_rs2_i = 7; ex_rd_i = 8;
    tick(); idle_in(); #1;
    chk("t3_busy", div_valid_o, 1);
    flush_i = 1'b1; #1;
    chk("t3_flush_divvalid", div_valid_o, 0);
    chk("t3_flush_wbvalid", wb_valid_o, 0);
    tick(); flush_i = 1'b0; ready_en = 1'b1; #1;
    chk("t3_idle_divvalid", div_valid_o, 0);
    chk("t3_idle_stall", stall_o, 0);
    drive(4'b1101, 32'd100, 32'd7, 5'd8, 32'd14);
    tick(); idle_in();
    wait_wb("t3");
    tick();
    chk("t3_sb_empty", sbq.size(), 0);

    // Test 4: divider never ready -> timeout after TO BUSY cycles.
    ready_en = 1'b0;
    chk("t4_err_before", err_o, 0);
    drive(4'b1101, 32'd9, 32'd3, 5'd11, 32'd0);
    for (int k = 1; k <= TO; k++) begin
      tick(); idle_in();
    end
    #1;
    chk("t4_wbvalid_at_TO", wb_valid_o, 0);
    chk("t4_err_at_TO", err_o, 0);
    tick(); #1;
    chk("t4_wbvalid_TO1", wb_valid_o, 1);
    chk("t4_err_TO1", err_o, 1);
    chk("t4_data_TO1", wb_data_o, 0);
    tick();
    ready_en = 1'b1; #1;
    chk("t4_err_sticky", err_o, 1);

    // Test 5: DIVU 100/7 back-to-back with ex_valid held.
    drive(4'b1101, 32'd100, 32'd7, 5'd12, 32'd14);
    tick(); #1;
    chk("t5_first_divvalid", div_valid_o, 1);
    tick(); #1;
    chk("t5_first_wbvalid", wb_valid_o, 1);
    chk("t5_hs_stall", stall_o, 0);
    tick();
    sbq.push_back('{rd: 5'd12, data: 32'd14}); #1;
    chk("t5_second_accept_stall", stall_o, 1);
    tick(); idle_in(); #1;
`ifdef DIV_RESULT_REUSE_EN
    chk("t5_second_wbvalid_N1", wb_valid_o, 1);
    chk("t5_second_divvalid_N1", div_valid_o, 0);
`else
    chk("t5_second_wbvalid_N1", wb_valid_o, 0);
    chk("t5_second_divvalid_N1", div_valid_o, 1);
`endif
    wait_wb("t5");
    tick();
    chk("t5_sb_empty", sbq.size(), 0);

    // Test 6: async reset in DONE.
    wb_ready_i = 1'b0;
    drive(4'b1110, 32'd100, 32'd7, 5'd13, 32'd2);
    tick(); idle_in();
    wait_wb("t6");
    #1;
    rst_n = 1'b0; #1;
    chk("t6_rst_wbvalid", wb_valid_o, 0);
    chk("t6_rst_stall", stall_o, 0);
    chk("t6_rst_err", err_o, 0);
    chk("t6_rst_data", wb_data_o, 0);
    chk("t6_rst_rd", wb_rd_o, 0);
    chk("t6_rst_div", {div_a_o, div_b_o, div_op_o, div_valid_o} == 0, 1);
    sbq.delete();
    tick(); rst_n = 1'b1; wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("t6_no_wb", wb_valid_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish by 200000");
    $fatal(1, "watchdog");
  end
endmodule
